// File: rtl/alu_seq.sv
// alu_seq: multi-cycle integer ALU.
// Single-cycle ops register their result one clock after start.
// Shifts iterate over a working register.
// Build option ALU_SHIFT4_EN: shifts step up to four positions per cycle
// instead of one. Results and the busy/done handshake are the same in both builds.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | iterative shift in progress, busy=1, start ignored
// DONE  | result/flags just updated, done=1 for this cycle, start accepted

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`endif
`ifndef ALU_SUB
`define ALU_SUB  4'd1
`endif
`ifndef ALU_AND
`define ALU_AND  4'd2
`endif
`ifndef ALU_OR
`define ALU_OR   4'd3
`endif
`ifndef ALU_XOR
`define ALU_XOR  4'd4
`endif
`ifndef ALU_SLT
`define ALU_SLT  4'd5
`endif
`ifndef ALU_SLTU
`define ALU_SLTU 4'd6
`endif
`ifndef ALU_SLL
`define ALU_SLL  4'd7
`endif
`ifndef ALU_SRL
`define ALU_SRL  4'd8
`endif
`ifndef ALU_SRA
`define ALU_SRA  4'd9
`endif
`ifndef ALU_PASS
`define ALU_PASS 4'd10
`endif

module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      ALUsel,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zf,
    output logic            cf,
    output logic            vf,
    output logic            sf,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]      state;
    logic [XLEN-1:0] work;
    logic [SHW-1:0]  cnt;
    logic [3:0]      sh_op;

    logic [SHW-1:0]  shamt;
    logic            is_shift;
    logic [XLEN:0]   add_w;
    logic [XLEN:0]   sub_w;
    logic [XLEN-1:0] imm_res;
    logic            imm_cf;
    logic            imm_vf;
    logic [SHW-1:0]  step;
    logic [SHW-1:0]  cnt_next;
    logic [XLEN-1:0] shifted;

    assign shamt    = b[SHW-1:0];
    assign is_shift = (ALUsel == `ALU_SLL) || (ALUsel == `ALU_SRL) || (ALUsel == `ALU_SRA);
    assign busy     = (state == SHIFT);
    assign done     = (state == DONE);

    // Single-cycle result and carry/overflow; a zero-amount shift passes a through.
    always_comb begin
        add_w   = {1'b0, a} + {1'b0, b};
        sub_w   = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
        imm_res = b;
        imm_cf  = 1'b0;
        imm_vf  = 1'b0;
        case (ALUsel)
            `ALU_ADD: begin
                imm_res = add_w[XLEN-1:0];
                imm_cf  = add_w[XLEN];
                imm_vf  = (a[XLEN-1] == b[XLEN-1]) && (add_w[XLEN-1] != a[XLEN-1]);
            end
            `ALU_SUB: begin
                imm_res = sub_w[XLEN-1:0];
                imm_cf  = sub_w[XLEN];
                imm_vf  = (a[XLEN-1] != b[XLEN-1]) && (sub_w[XLEN-1] != a[XLEN-1]);
            end
            `ALU_AND:  imm_res = a & b;
            `ALU_OR:   imm_res = a | b;
            `ALU_XOR:  imm_res = a ^ b;
            `ALU_SLT:  imm_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            `ALU_SLTU: imm_res = {{(XLEN-1){1'b0}}, (a < b)};
            `ALU_SLL, `ALU_SRL, `ALU_SRA: imm_res = a;
            default:   imm_res = b;
        endcase
    end

    // One shift step on the working register.
    always_comb begin
`ifdef ALU_SHIFT4_EN
        step = (cnt > SHW'(4)) ? SHW'(4) : cnt;
`else
        step = SHW'(1);
`endif
        cnt_next = cnt - step;
        case (sh_op)
            `ALU_SLL: shifted = work << step;
            `ALU_SRA: shifted = $signed(work) >>> step;
            default:  shifted = work >> step;
        endcase
    end

    // Sequencer: accept in IDLE/DONE, iterate in SHIFT, register result on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            sh_op  <= '0;
            result <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            vf     <= 1'b0;
            sf     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (is_shift && (shamt != '0)) begin
                            work  <= a;
                            cnt   <= shamt;
                            sh_op <= ALUsel;
                            state <= SHIFT;
                        end else begin
                            result <= imm_res;
                            zf     <= (imm_res == '0);
                            cf     <= imm_cf;
                            vf     <= imm_vf;
                            sf     <= imm_res[XLEN-1];
                            state  <= DONE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt_next;
                    if (cnt_next == '0) begin
                        result <= shifted;
                        zf     <= (shifted == '0);
                        cf     <= 1'b0;
                        vf     <= 1'b0;
                        sf     <= shifted[XLEN-1];
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
